// File: rtl/sc_bgsched_pkg.sv
// Shared types for the background lane scheduler: FSM states, shift codes, divisor scaling.
// Pure definitions; no timing or backpressure of its own.
package sc_bgsched_pkg;

  typedef enum logic [2:0] {
    RESET,
    IDLE,
    CLEAR,
    WAIT_REL,
    RUN,
    PAUSE
  } bgState_t;

  localparam logic [1:0] SHIFT_LEFT  = 2'b10;
  localparam logic [1:0] SHIFT_RIGHT = 2'b01;
  localparam logic [1:0] SHIFT_HOLD  = 2'b11;

  // Faster levels halve the divisor per step, never below one tick per shift.
  function automatic int scaledDiv(input int div, input int lvl);
    int d;
    d = div >> lvl;
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/sc_rr_arbiter.sv
// Round-robin pick of the first pending lane at or after ptr; purely combinational, zero latency.
// No backpressure: the caller decides whether a grant is consumed.
module sc_rr_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic [NUM_LANES-1:0] pending_In,
  input  logic [LANE_W-1:0]    ptr_In,
  output logic                 grantValid_Out,
  output logic [LANE_W-1:0]    grant_Out
);

  function automatic logic [LANE_W-1:0] wrapIdx(input logic [LANE_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_LANES) sum = sum - NUM_LANES;
    return LANE_W'(sum);
  endfunction

  // Scan from the farthest offset down so the nearest pending lane is assigned last and wins.
  always_comb begin
    grantValid_Out = 1'b0;
    grant_Out      = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (pending_In[wrapIdx(ptr_In, k)]) begin
        grantValid_Out = 1'b1;
        grant_Out      = wrapIdx(ptr_In, k);
      end
    end
  end

endmodule

// File: rtl/sc_lane_scheduler.sv
// Frogger background scheduler: shared prescaler, per-lane divisors, round-robin shift strobes.
// Tick-to-strobe 2 cycles, one strobe per cycle max; no backpressure, a re-tick on a pending lane sets overrun.
module sc_lane_scheduler
  import sc_bgsched_pkg::*;
#(
  parameter int                         NUM_LANES   = 4,
  parameter int                         BASE_PERIOD = 2_500_000,
  parameter int                         PRESC_W     = 22,
  parameter int                         DIV_W       = 4,
  parameter logic [NUM_LANES*DIV_W-1:0] LANE_DIV    = {4'd4, 4'd3, 4'd2, 4'd1},
  parameter logic [NUM_LANES-1:0]       LANE_DIR    = 4'b1010,
  parameter int                         LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic              SC_STATEMACHINEBACKG_CLOCK_50,
  input  logic              SC_STATEMACHINEBACKG_RESET_InHigh,
  input  logic              startButton_InLow,
  input  logic              pause_InLow,
  input  logic [1:0]        level_In,
  output logic [LANE_W-1:0] lane_sel_Out,
  output logic [1:0]        shiftselection_Out,
  output logic              shiftstrobe_OutLow,
  output logic              clear_OutLow,
  output logic              running_Out,
  output logic              overrun_Out
);

  bgState_t             state, nextState;
  logic [PRESC_W-1:0]   presc;
  logic [DIV_W-1:0]     laneCnt [NUM_LANES];
  logic [NUM_LANES-1:0] pending, fireMask, grantMask;
  logic [LANE_W-1:0]    ptr, grant, laneSel;
  logic                 arbValid, grantValid, baseTick;
  logic                 overrun, strobeN;
  logic [1:0]           shiftSel;

  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) state <= RESET;
    else                                   state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      RESET:    nextState = IDLE;
      IDLE:     if (!startButton_InLow) nextState = CLEAR;
      CLEAR:    nextState = WAIT_REL;
      WAIT_REL: if (startButton_InLow) nextState = RUN;
      RUN: begin
        if (!startButton_InLow) nextState = CLEAR;
        else if (!pause_InLow)  nextState = PAUSE;
      end
      PAUSE: begin
        if (!startButton_InLow) nextState = CLEAR;
        else if (pause_InLow)   nextState = RUN;
      end
      default:  nextState = RESET;
    endcase
  end

  assign clear_OutLow = !((state == RESET) || (state == CLEAR));
  assign running_Out  = (state == RUN);

  assign baseTick = (state == RUN) && (presc == PRESC_W'(BASE_PERIOD - 1));

  // A divisor of zero leaves the lane permanently idle.
  always_comb begin
    fireMask = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (baseTick && (LANE_DIV[i*DIV_W +: DIV_W] != '0) && (laneCnt[i] <= DIV_W'(1)))
        fireMask[i] = 1'b1;
    end
  end

  sc_rr_arbiter #(
    .NUM_LANES(NUM_LANES),
    .LANE_W   (LANE_W)
  ) u_arb (
    .pending_In    (pending),
    .ptr_In        (ptr),
    .grantValid_Out(arbValid),
    .grant_Out     (grant)
  );

  assign grantValid = arbValid && (state == RUN);
  assign grantMask  = grantValid ? (NUM_LANES'(1) << grant) : '0;

  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      presc    <= '0;
      for (int i = 0; i < NUM_LANES; i++) laneCnt[i] <= '0;
      pending  <= '0;
      ptr      <= '0;
      overrun  <= 1'b0;
      strobeN  <= 1'b1;
      shiftSel <= SHIFT_HOLD;
      laneSel  <= '0;
    end else begin
      strobeN  <= 1'b1;
      shiftSel <= SHIFT_HOLD;
      if (state == CLEAR) begin
        presc   <= '0;
        for (int i = 0; i < NUM_LANES; i++)
          laneCnt[i] <= DIV_W'(scaledDiv(int'(LANE_DIV[i*DIV_W +: DIV_W]), int'(level_In)));
        pending <= '0;
        ptr     <= '0;
        overrun <= 1'b0;
      end else if (state == RUN) begin
        presc <= baseTick ? '0 : presc + 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
          if (baseTick && (LANE_DIV[i*DIV_W +: DIV_W] != '0)) begin
            if (fireMask[i])
              laneCnt[i] <= DIV_W'(scaledDiv(int'(LANE_DIV[i*DIV_W +: DIV_W]), int'(level_In)));
            else
              laneCnt[i] <= laneCnt[i] - 1'b1;
          end
        end
        // A lane granted in its own tick cycle simply re-arms; only an unserved re-tick is an overrun.
        pending <= (pending & ~grantMask) | fireMask;
        if (|(fireMask & pending & ~grantMask)) overrun <= 1'b1;
        if (grantValid) begin
          strobeN  <= 1'b0;
          laneSel  <= grant;
          shiftSel <= LANE_DIR[grant] ? SHIFT_RIGHT : SHIFT_LEFT;
          ptr      <= (grant == LANE_W'(NUM_LANES - 1)) ? '0 : grant + 1'b1;
        end
      end
    end
  end

  assign lane_sel_Out       = laneSel;
  assign shiftselection_Out = shiftSel;
  assign shiftstrobe_OutLow = strobeN;
  assign overrun_Out        = overrun;

endmodule
